// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MAX_NUM = 32;
  localparam int MAX_IW  = 5;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_NUM-1:0] oh);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (oh[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// rtl/wrr_arbiter_if.sv - requester/downstream handshake bundle for wrr_arbiter
interface wrr_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM = 4,
  parameter int WW  = 4
);
  localparam int IW = idx_width(NUM);

  logic [NUM-1:0]    req_i;
  logic [NUM*WW-1:0] weight_i;
  logic              ready_i;
  logic              last_i;
  logic [NUM-1:0]    gnt_o;
  logic [IW-1:0]     gnt_idx_o;
  logic              gnt_valid_o;

  modport master (
    output req_i, weight_i, ready_i, last_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o
  );

  modport slave (
    input  req_i, weight_i, ready_i, last_i,
    output gnt_o, gnt_idx_o, gnt_valid_o
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority one-hot pick starting at ptr, wrapping LSB-first
module rr_pick #(
  parameter int NUM = 4,
  parameter int IW  = 2
) (
  input  logic [NUM-1:0] vec,
  input  logic [IW-1:0]  ptr,
  output logic [NUM-1:0] pick
);

  logic [NUM-1:0] mask;
  logic [NUM-1:0] masked;
  logic [NUM-1:0] hi_pick;
  logic [NUM-1:0] lo_pick;

  // x & -x isolates the lowest set bit: a fixed LSB-first priority pick
  assign mask    = ~((NUM'(1) << ptr) - NUM'(1));
  assign masked  = vec & mask;
  assign hi_pick = masked & (~masked + NUM'(1));
  assign lo_pick = vec & (~vec + NUM'(1));
  assign pick    = (masked != '0) ? hi_pick : lo_pick;

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with per-requester credits and transfer lock
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM = 4,
  parameter int WW  = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  wrr_arbiter_if.slave bus
);

  localparam int IW = idx_width(NUM);

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [WW-1:0]  credit [NUM];
  logic [NUM-1:0] gnt_q;
  logic [IW-1:0]  gnt_idx_q;
  logic           gnt_valid_q;

  logic [NUM-1:0] has_credit;
  logic [NUM-1:0] elig;
  logic           need_reload;
  logic [NUM-1:0] pick_vec;
  logic [NUM-1:0] pick;
  logic           done;

  always_comb begin
    has_credit = '0;
    for (int i = 0; i < NUM; i++) begin
      has_credit[i] = (credit[i] != '0);
    end
  end

  // An exhausted eligible set reloads this cycle, so the pick sees every requester
  assign elig        = bus.req_i & has_credit;
  assign need_reload = (elig == '0);
  assign pick_vec    = need_reload ? bus.req_i : elig;
  assign done        = bus.ready_i && bus.last_i;

  rr_pick #(
    .NUM (NUM),
    .IW  (IW)
  ) u_rr_pick (
    .vec  (pick_vec),
    .ptr  (ptr),
    .pick (pick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        credit[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i != '0) begin
            if (need_reload) begin
              for (int i = 0; i < NUM; i++) begin
                credit[i] <= (bus.weight_i[i*WW +: WW] == '0) ? WW'(1)
                                                              : bus.weight_i[i*WW +: WW];
              end
            end
            gnt_q       <= pick;
            gnt_idx_q   <= IW'(onehot_to_idx(MAX_NUM'(pick)));
            gnt_valid_q <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            if (credit[gnt_idx_q] != '0) begin
              credit[gnt_idx_q] <= credit[gnt_idx_q] - WW'(1);
            end
            // Keep priority while credit remains; otherwise rotate past the winner
            if (credit[gnt_idx_q] <= WW'(1)) begin
              ptr <= (gnt_idx_q == IW'(NUM - 1)) ? '0 : gnt_idx_q + IW'(1);
            end else begin
              ptr <= gnt_idx_q;
            end
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = gnt_idx_q;
  assign bus.gnt_valid_o = gnt_valid_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - directed and randomized checks of wrr_arbiter against a behavioural model
module tb_wrr_arbiter;

  localparam int NUM = 4;
  localparam int WW  = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  int cred [NUM];
  int w    [NUM];
  int mptr  = 0;
  int mbusy = 0;
  int mg    = 0;
  int glog [$];

  wrr_arbiter_if #(.NUM(NUM), .WW(WW)) bus ();

  wrr_arbiter #(.NUM(NUM), .WW(WW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < NUM; i++) bus.weight_i[i*WW +: WW] = WW'(w[i]);
  endtask

  // Model advances on the edge using the stimulus currently applied, then compares
  task automatic step();
    int any;
    int found;
    int idx;
    @(posedge clk_i);
    if (rst_i) begin
      mbusy = 0; mg = 0; mptr = 0;
      for (int i = 0; i < NUM; i++) cred[i] = 0;
    end else if (mbusy == 0) begin
      if (bus.req_i != '0) begin
        any = 0;
        for (int i = 0; i < NUM; i++) if (bus.req_i[i] && cred[i] > 0) any = 1;
        if (any == 0) for (int i = 0; i < NUM; i++) cred[i] = (w[i] == 0) ? 1 : w[i];
        found = 0;
        for (int k = 0; k < NUM; k++) begin
          idx = (mptr + k) % NUM;
          if (found == 0 && bus.req_i[idx] && cred[idx] > 0) begin
            mg = idx;
            found = 1;
          end
        end
        mbusy = 1;
        glog.push_back(mg);
      end
    end else if (bus.ready_i && bus.last_i) begin
      if (cred[mg] > 0) cred[mg] = cred[mg] - 1;
      mptr  = (cred[mg] == 0) ? (mg + 1) % NUM : mg;
      mbusy = 0;
    end
    #1;
    check("gnt", 32'(bus.gnt_o), (mbusy != 0) ? (32'd1 << mg) : 32'd0);
    check("gnt_idx", 32'(bus.gnt_idx_o), (mbusy != 0) ? 32'(mg) : 32'd0);
    check("gnt_valid", 32'(bus.gnt_valid_o), 32'(mbusy));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    glog.delete();
  endtask

  task automatic run_grants(input int n);
    int budget;
    budget = 200;
    while (glog.size() < n && budget > 0) begin
      step();
      budget--;
    end
    check("grant_budget", 32'(glog.size() >= n), 32'd1);
  endtask

  task automatic expect_seq(input string tag, input int exp [8], input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  initial begin
    bus.req_i    = '0;
    bus.ready_i  = 1'b0;
    bus.last_i   = 1'b0;
    set_w(1, 1, 1, 1);
    rst_i = 1'b1;
    step();
    check("reset_gnt", 32'(bus.gnt_o), 32'd0);

    // Equal weights rotate through all requesters
    do_reset();
    set_w(1, 1, 1, 1);
    bus.req_i = 4'b1111; bus.ready_i = 1'b1; bus.last_i = 1'b1;
    run_grants(5);
    expect_seq("rr_equal", '{0, 1, 2, 3, 0, 0, 0, 0}, 5);

    // Weight 3 vs 1
    do_reset();
    set_w(3, 1, 1, 1);
    bus.req_i = 4'b0011;
    run_grants(8);
    expect_seq("weighted", '{0, 0, 0, 1, 0, 0, 0, 1}, 8);

    // Multi-beat lock: last without ready does not complete
    do_reset();
    set_w(1, 1, 1, 1);
    bus.req_i = 4'b0100; bus.ready_i = 1'b0; bus.last_i = 1'b1;
    step();
    bus.req_i = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_hold", 32'(bus.gnt_o), 32'b0100);
    end
    bus.ready_i = 1'b1;
    step();
    check("lock_release", 32'(bus.gnt_o), 32'd0);
    bus.ready_i = 1'b0;
    step();
    check("after_bubble", 32'(bus.gnt_valid_o), 32'd1);
    bus.ready_i = 1'b1;
    step();

    // Zero weights behave as one
    do_reset();
    set_w(0, 0, 0, 0);
    bus.req_i = 4'b1001; bus.ready_i = 1'b1; bus.last_i = 1'b1;
    run_grants(4);
    expect_seq("zero_weight", '{0, 3, 0, 3, 0, 0, 0, 0}, 4);

    // Reset during a held grant
    do_reset();
    set_w(1, 1, 1, 1);
    bus.req_i = 4'b0010; bus.ready_i = 1'b0;
    step();
    bus.req_i = 4'b0110; rst_i = 1'b1;
    step();
    check("rst_mid_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_mid_valid", 32'(bus.gnt_valid_o), 32'd0);
    rst_i = 1'b0;
    glog.delete();
    run_grants(1);
    expect_seq("rst_first", '{1, 0, 0, 0, 0, 0, 0, 0}, 1);

    // New weights only take effect at the next reload
    do_reset();
    set_w(2, 2, 1, 1);
    bus.req_i = 4'b0011; bus.ready_i = 1'b1; bus.last_i = 1'b1;
    run_grants(1);
    set_w(4, 4, 1, 1);
    run_grants(8);
    expect_seq("weight_change", '{0, 0, 1, 1, 0, 0, 0, 0}, 8);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req_i = NUM'($urandom);
      if ($urandom_range(0, 31) == 0) set_w($urandom_range(0, 15), $urandom_range(0, 15),
                                            $urandom_range(0, 15), $urandom_range(0, 15));
      bus.ready_i = 1'($urandom);
      bus.last_i  = 1'($urandom);
      rst_i       = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
